// File: rtl/add_n_seq.sv
// add_n_seq: multi-cycle WIDTH-bit adder/subtractor, one CHUNK-bit slice per clock
// with the carry rippled through a register and a start/busy/done handshake.
module add_n_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic             sub_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = NCH > 1 ? $clog2(NCH) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("add_n_seq: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_work, r_sum, w_work;
    logic [KW-1:0]    r_k;
    logic             r_cy, r_carry, r_ovf, r_done;
    logic [CHUNK:0]   w_slice;
    logic             w_last, w_ovf;
    int               w_base;

    always_comb begin
        w_base  = int'(r_k) * CHUNK;
        w_slice = {1'b0, r_a[w_base +: CHUNK]} + {1'b0, r_b[w_base +: CHUNK]} + {{CHUNK{1'b0}}, r_cy};
        w_last  = r_k == KW'(NCH - 1);
        w_work  = r_work;
        w_work[w_base +: CHUNK] = w_slice[CHUNK-1:0];
        // carry into the MSB is recovered from its sum bit; only valid on the last slice
        w_ovf   = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_slice[CHUNK-1] ^ w_slice[CHUNK];
        w_next  = r_state == IDLE ? (start_i ? RUN : IDLE) : (w_last ? IDLE : RUN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_sum   <= '0;
            r_k     <= '0;
            r_cy    <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            if (r_state == IDLE) begin
                if (start_i) begin
                    r_a    <= a_i;
                    r_b    <= sub_i ? ~b_i : b_i;
                    r_cy   <= sub_i ? ~c_i : c_i;
                    r_k    <= '0;
                    r_work <= '0;
                end
            end else begin
                r_work <= w_work;
                r_cy   <= w_slice[CHUNK];
                r_k    <= w_last ? '0 : r_k + 1'b1;
                if (w_last) begin
                    r_sum   <= w_work;
                    r_carry <= w_slice[CHUNK];
                    r_ovf   <= w_ovf;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign busy_o  = r_state == RUN;
    assign done_o  = r_done;
    assign sum_o   = r_sum;
    assign carry_o = r_carry;
    assign ovf_o   = r_ovf;
endmodule
